// File: rtl/mips150_lsu_ctrl.sv
// Load/store sequencer: drives a ready/rvalid data memory for MIPS150 EX ops and returns extended load data.
// Latency: store 3 cycles, load 3 cycles (rvalid with ready) or 4+; illegal ops finish in 2 with err.
// Backpressure: stall holds the pipeline while an op is in flight; mem_ready/mem_rvalid pace progress, timeout aborts.
//
// Ports: op_* capture a decoded memory op in IDLE; stall/done/err/load_data report to the pipeline;
// mem_req/mem_addr/mem_we/mem_wdata form the request side, mem_ready/mem_rvalid/mem_rdata the response side.
module mips150_lsu_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [1:0]  op_memwrite,
    input  logic [2:0]  op_mask,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [1:0]       r_memwrite;
    logic [2:0]       r_mask;
    logic [1:0]       r_off;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [CNT_W-1:0] cnt;

    logic             illegal;
    logic [3:0]       we_n;
    logic [31:0]      wdata_n;
    logic             tmo_hit;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;

    // Alignment check on the incoming op; unknown load masks are rejected outright.
    always_comb begin
        illegal = 1'b0;
        case (op_memwrite)
            2'b00: begin
                case (op_mask)
                    3'b000, 3'b011: illegal = 1'b0;
                    3'b001, 3'b100: illegal = op_addr[0];
                    3'b010:         illegal = |op_addr[1:0];
                    default:        illegal = 1'b1;
                endcase
            end
            2'b01:   illegal = 1'b0;
            2'b10:   illegal = op_addr[0];
            default: illegal = |op_addr[1:0];
        endcase
    end

    // Store lanes: data is replicated so the enabled lanes always see the right bytes.
    always_comb begin
        we_n    = 4'b0000;
        wdata_n = 32'd0;
        case (op_memwrite)
            2'b01: begin
                we_n    = 4'b0001 << op_addr[1:0];
                wdata_n = {4{op_wdata[7:0]}};
            end
            2'b10: begin
                we_n    = 4'b0011 << {op_addr[1], 1'b0};
                wdata_n = {2{op_wdata[15:0]}};
            end
            2'b11: begin
                we_n    = 4'b1111;
                wdata_n = op_wdata;
            end
            default: begin
            end
        endcase
    end

    // A zero TIMEOUT disables the abort entirely.
    assign tmo_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    assign mem_req = (state == REQ);
    assign done    = (state == DONE);
    assign err     = (state == DONE) && r_err;
    assign stall   = (state == IDLE) ? op_valid : (state != DONE);

    always_comb begin
        case (r_off)
            2'd0:    sel_byte = r_rdata[7:0];
            2'd1:    sel_byte = r_rdata[15:8];
            2'd2:    sel_byte = r_rdata[23:16];
            default: sel_byte = r_rdata[31:24];
        endcase
        sel_half = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];
    end

    always_comb begin
        load_data = 32'd0;
        if ((state == DONE) && !r_err && (r_memwrite == 2'b00)) begin
            case (r_mask)
                3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
                3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
                3'b010:  load_data = r_rdata;
                3'b011:  load_data = {24'd0, sel_byte};
                3'b100:  load_data = {16'd0, sel_half};
                default: load_data = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            r_memwrite <= 2'b00;
            r_mask     <= 3'b000;
            r_off      <= 2'b00;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
            cnt        <= '0;
            mem_addr   <= 30'd0;
            mem_we     <= 4'b0000;
            mem_wdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    r_err <= 1'b0;
                    if (op_valid) begin
                        r_memwrite <= op_memwrite;
                        r_mask     <= op_mask;
                        r_off      <= op_addr[1:0];
                        r_rdata    <= 32'd0;
                        mem_addr   <= op_addr[31:2];
                        cnt        <= '0;
                        if (illegal) begin
                            state     <= DONE;
                            r_err     <= 1'b1;
                            mem_we    <= 4'b0000;
                            mem_wdata <= 32'd0;
                        end else begin
                            state     <= REQ;
                            mem_we    <= we_n;
                            mem_wdata <= wdata_n;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_we <= 4'b0000;
                        cnt    <= '0;
                        if (r_memwrite != 2'b00) begin
                            state <= DONE;
                        end else if (mem_rvalid) begin
                            r_rdata <= mem_rdata;
                            state   <= DONE;
                        end else begin
                            state <= RESP;
                        end
                    end else if (tmo_hit) begin
                        mem_we <= 4'b0000;
                        r_err  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        r_rdata <= mem_rdata;
                        state   <= DONE;
                    end else if (tmo_hit) begin
                        r_err <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_err <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
